// File: rtl/mux_8_to_1_arbiter_if.sv
// Bundle between eight producers, the round-robin arbiter and one consumer.
// The arbiter takes the slave side; the producer/consumer environment takes the master side.
interface mux_8_to_1_arbiter_if #(
    parameter int N_BITS = 8
);
    logic [7:0]        Request;
    logic [N_BITS-1:0] Data_0;
    logic [N_BITS-1:0] Data_1;
    logic [N_BITS-1:0] Data_2;
    logic [N_BITS-1:0] Data_3;
    logic [N_BITS-1:0] Data_4;
    logic [N_BITS-1:0] Data_5;
    logic [N_BITS-1:0] Data_6;
    logic [N_BITS-1:0] Data_7;
    logic              Out_Ready;
    logic              Out_Valid;
    logic [N_BITS-1:0] Mux_Output;
    logic [2:0]        Selector;
    logic [7:0]        Grant;
    logic [7:0]        Ack;

    modport master (
        output Request, Data_0, Data_1, Data_2, Data_3,
               Data_4, Data_5, Data_6, Data_7, Out_Ready,
        input  Out_Valid, Mux_Output, Selector, Grant, Ack
    );

    modport slave (
        input  Request, Data_0, Data_1, Data_2, Data_3,
               Data_4, Data_5, Data_6, Data_7, Out_Ready,
        output Out_Valid, Mux_Output, Selector, Grant, Ack
    );
endinterface

// File: rtl/mux_8_to_1_arbiter.sv
// Round-robin arbiter that owns the 8-to-1 mux select and presents the chosen word
// downstream on a valid/ready handshake, acknowledging each transfer to its owner.
module mux_8_to_1_arbiter #(
    parameter int N_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    mux_8_to_1_arbiter_if.slave    bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_p1, state_nxt;
    logic [2:0]        ptr_p1, ptr_nxt;
    logic              vld_p1, vld_nxt;
    logic [N_BITS-1:0] word_p1, word_nxt;
    logic [2:0]        sel_p1, sel_nxt;
    logic [7:0]        grant_p1, grant_nxt;
    logic [3:0]        pick;
    logic [N_BITS-1:0] data_arr [8];

    // Returns {found, index} of the first set bit at or after start, wrapping 7->0.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] start);
        logic [3:0] r;
        logic [2:0] idx;
        r = 4'b0;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (req[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign data_arr[0] = bus.Data_0;
    assign data_arr[1] = bus.Data_1;
    assign data_arr[2] = bus.Data_2;
    assign data_arr[3] = bus.Data_3;
    assign data_arr[4] = bus.Data_4;
    assign data_arr[5] = bus.Data_5;
    assign data_arr[6] = bus.Data_6;
    assign data_arr[7] = bus.Data_7;

    always_comb begin
        state_nxt = state_p1;
        ptr_nxt   = ptr_p1;
        vld_nxt   = vld_p1;
        word_nxt  = word_p1;
        sel_nxt   = sel_p1;
        grant_nxt = grant_p1;
        pick      = 4'b0;
        case (state_p1)
            IDLE: pick = rr_pick(bus.Request, ptr_p1);
            BUSY: begin
                if (bus.Out_Ready) begin
                    // The served requester is masked so a lone requester cannot hog the channel.
                    ptr_nxt = sel_p1 + 3'd1;
                    pick    = rr_pick(bus.Request & ~grant_p1, sel_p1 + 3'd1);
                    if (!pick[3]) begin
                        state_nxt = IDLE;
                        vld_nxt   = 1'b0;
                        grant_nxt = 8'h00;
                    end
                end
            end
        endcase
        if (pick[3]) begin
            state_nxt = BUSY;
            vld_nxt   = 1'b1;
            sel_nxt   = pick[2:0];
            grant_nxt = 8'b1 << pick[2:0];
            word_nxt  = data_arr[pick[2:0]];
        end
    end

    // Stage 1: registered grant, select and held word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p1 <= IDLE;
            ptr_p1   <= 3'd0;
            vld_p1   <= 1'b0;
            word_p1  <= '0;
            sel_p1   <= 3'd0;
            grant_p1 <= 8'h00;
        end else begin
            state_p1 <= state_nxt;
            ptr_p1   <= ptr_nxt;
            vld_p1   <= vld_nxt;
            word_p1  <= word_nxt;
            sel_p1   <= sel_nxt;
            grant_p1 <= grant_nxt;
        end
    end

    assign bus.Out_Valid  = vld_p1;
    assign bus.Mux_Output = word_p1;
    assign bus.Selector   = sel_p1;
    assign bus.Grant      = grant_p1;
    assign bus.Ack        = (vld_p1 && bus.Out_Ready) ? grant_p1 : 8'h00;
endmodule

// File: tb/tb_mux_8_to_1_arbiter.sv
// Bench for mux_8_to_1_arbiter: directed scenarios with literal expectations plus
// protocol-following random requesters, all compared every cycle against a behavioural model.
module tb_mux_8_to_1_arbiter;
    localparam int N_BITS = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        req = 8'h00;
    logic              rdy = 1'b0;
    logic [N_BITS-1:0] d [8];

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit                m_valid = 1'b0;
    int                m_sel = 0;
    int                m_ptr = 0;
    logic [N_BITS-1:0] m_word = '0;
    logic [7:0]        m_last_ack = 8'h00;
    int                waits [8];
    int                fair_max = 0;

    always #5 clk = ~clk;

    mux_8_to_1_arbiter_if #(.N_BITS(N_BITS)) bus ();

    assign bus.Request   = req;
    assign bus.Out_Ready = rdy;
    assign bus.Data_0    = d[0];
    assign bus.Data_1    = d[1];
    assign bus.Data_2    = d[2];
    assign bus.Data_3    = d[3];
    assign bus.Data_4    = d[4];
    assign bus.Data_5    = d[5];
    assign bus.Data_6    = d[6];
    assign bus.Data_7    = d[7];

    mux_8_to_1_arbiter #(.N_BITS(N_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First requester at or after start in circular order, -1 when none.
    function automatic int first_req(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid    = 1'b0;
            m_sel      = 0;
            m_ptr      = 0;
            m_word     = '0;
            m_last_ack = 8'h00;
            for (int i = 0; i < 8; i++) waits[i] = 0;
        end else begin
            int w;
            logic [7:0] masked;
            m_last_ack = 8'h00;
            if (!m_valid) begin
                w = first_req(req, m_ptr);
                if (w >= 0) begin
                    m_valid = 1'b1; m_sel = w; m_word = d[w];
                end
            end else if (rdy) begin
                m_last_ack = 8'h01 << m_sel;
                for (int i = 0; i < 8; i++) begin
                    if (i != m_sel && req[i]) waits[i]++;
                    if (waits[i] > fair_max) fair_max = waits[i];
                end
                waits[m_sel] = 0;
                m_ptr = (m_sel + 1) % 8;
                masked = req;
                masked[m_sel] = 1'b0;
                w = first_req(masked, m_ptr);
                if (w >= 0) begin
                    m_sel = w; m_word = d[w];
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int i = 0; i < 8; i++) if (!req[i]) waits[i] = 0;
        end
    end

    always @(negedge clk) begin
        logic [7:0] eg;
        eg = m_valid ? (8'h01 << m_sel) : 8'h00;
        chk("out_valid",  bus.Out_Valid,  m_valid);
        chk("grant",      bus.Grant,      eg);
        chk("selector",   bus.Selector,   m_sel);
        chk("mux_output", bus.Mux_Output, m_word);
        chk("ack",        bus.Ack,        (m_valid && rdy) ? eg : 8'h00);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] rot [8];
        int fseq [6];
        rot  = '{8'hEB, 8'h7D, 8'hAA, 8'h03, 8'hFF, 8'h0C, 8'h50, 8'h1E};
        fseq = '{6, 1, 6, 1, 6, 1};
        for (int i = 0; i < 8; i++) d[i] = 8'h5A;

        // reset held with every requester active and the consumer ready
        reset = 1'b1; req = 8'hFF; rdy = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_valid", bus.Out_Valid, 1'b0);
            chk("rst_grant", bus.Grant, 8'h00);
            chk("rst_sel",   bus.Selector, 3'd0);
            chk("rst_mux",   bus.Mux_Output, 8'h00);
            chk("rst_ack",   bus.Ack, 8'h00);
        end
        req = 8'h00;
        tick();
        reset = 1'b0;

        // single request, no backpressure
        d[2] = 8'hAA; req = 8'h04; rdy = 1'b1;
        tick();
        chk("single_sel",   bus.Selector, 3'd2);
        chk("single_grant", bus.Grant, 8'h04);
        chk("single_mux",   bus.Mux_Output, 8'hAA);
        chk("single_ack",   bus.Ack, 8'h04);
        req = 8'h00;
        tick();
        chk("single_idle_valid", bus.Out_Valid, 1'b0);
        chk("single_idle_sel",   bus.Selector, 3'd2);

        // full rotation from a fresh pointer
        do_reset();
        for (int i = 0; i < 8; i++) d[i] = rot[i];
        req = 8'hFF; rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rot_valid", bus.Out_Valid, 1'b1);
            chk("rot_sel",   bus.Selector, k);
            chk("rot_mux",   bus.Mux_Output, rot[k]);
            chk("rot_ack",   bus.Ack, 8'h01 << k);
            req[k] = 1'b0;
        end
        tick();
        chk("rot_end_valid", bus.Out_Valid, 1'b0);

        // backpressure
        d[4] = 8'hFF; req = 8'h10; rdy = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", bus.Out_Valid, 1'b1);
            chk("bp_grant", bus.Grant, 8'h10);
            chk("bp_mux",   bus.Mux_Output, 8'hFF);
            chk("bp_ack",   bus.Ack, 8'h00);
            if (c < 4) tick();
        end
        rdy = 1'b1;
        #1;
        chk("bp_ack_rise", bus.Ack, 8'h10);
        tick();
        req = 8'h00;
        chk("bp_done_valid", bus.Out_Valid, 1'b0);

        // two continuous requesters alternate
        req = 8'h42; rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("fair_sel",   bus.Selector, fseq[k]);
            chk("fair_valid", bus.Out_Valid, 1'b1);
        end
        req = 8'h00;
        tick();
        tick();

        // reset in the middle of a held transfer
        req = 8'h20; rdy = 1'b0;
        tick();
        chk("mid_grant", bus.Grant, 8'h20);
        #2;
        rdy = 1'b1; reset = 1'b1;
        #1;
        chk("mid_rst_valid", bus.Out_Valid, 1'b0);
        chk("mid_rst_grant", bus.Grant, 8'h00);
        chk("mid_rst_ack",   bus.Ack, 8'h00);
        req = 8'h21;
        tick();
        reset = 1'b0;
        tick();
        chk("mid_regrant_sel",   bus.Selector, 3'd0);
        chk("mid_regrant_grant", bus.Grant, 8'h01);

        // random requesters that follow the request/ack protocol
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < 8; i++) begin
                if (m_last_ack[i]) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                    else d[i] = N_BITS'($urandom);
                end else if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                    d[i]   = N_BITS'($urandom);
                end
            end
            rdy = ($urandom_range(3, 0) != 0);
        end
        tick();
        chk("fairness_bound", (fair_max <= 8) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
